// File: rtl/ram_pkg.sv
// Shared definitions for the parity-protected dual-port RAM family:
// collision-mode names, byte-count helper and per-byte parity function.
package ram_pkg;

    localparam string CM_READ_FIRST  = "READ_FIRST";
    localparam string CM_WRITE_FIRST = "WRITE_FIRST";

    // Widest word the parity helper handles; callers zero-extend into it
    // and truncate the result back to their own byte count.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BYTES      = MAX_DATA_WIDTH / 8;

    function automatic int NUM_BYTES(input int data_width);
        return data_width / 8;
    endfunction

    // Even parity of each byte: bit i is the XOR of data[8i+7:8i].
    function automatic logic [MAX_BYTES-1:0] byte_parity(input logic [MAX_DATA_WIDTH-1:0] data);
        logic [MAX_BYTES-1:0] par;
        par = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            par[i] = ^data[8*i +: 8];
        end
        return par;
    endfunction

endpackage

// File: rtl/ram_parity_chk.sv
// Combinational parity checker: recomputes per-byte parity of a word and
// flags any byte whose stored parity bit disagrees.
module ram_parity_chk
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NB         = NUM_BYTES(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [NB-1:0]         par,
    output logic                  err
);

    logic [NB-1:0] mismatch;

    assign mismatch = NB'(byte_parity(MAX_DATA_WIDTH'(data))) ^ par;
    assign err      = |mismatch;

endmodule

// File: rtl/dp_ram_parity.sv
// Simple dual-port RAM (one write, one read port) with byte enables,
// per-byte stored parity, selectable collision behaviour and a one- or
// two-cycle read latency. Memory contents are not reset.
module dp_ram_parity
    import ram_pkg::*;
#(
    parameter int    DATA_WIDTH     = 16,
    parameter int    DEPTH          = 1024,
    parameter int    ADDR_SIZE      = 10,
    parameter int    DOUT_PIPELINE  = 1,
    parameter string COLLISION_MODE = "READ_FIRST",
    parameter int    PARITY_ENABLE  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_SIZE-1:0]    wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    inj_err,
    input  logic                    rd_en,
    input  logic [ADDR_SIZE-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    parity_err,
    output logic                    err_sticky
);

    localparam int NB          = NUM_BYTES(DATA_WIDTH);
    localparam int WORD_W      = DATA_WIDTH + NB;
    localparam int IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit WRITE_FIRST = (COLLISION_MODE == CM_WRITE_FIRST);
    localparam logic [ADDR_SIZE:0] DEPTH_A = (ADDR_SIZE+1)'(DEPTH);

    // Each word is stored as {parity[NB-1:0], data[DATA_WIDTH-1:0]}.
    logic [WORD_W-1:0] mem [DEPTH];

    logic          wr_ok;
    logic          rd_ok;
    logic          collide;
    logic [NB-1:0] wr_par;

    assign wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_A);
    assign rd_ok   = {1'b0, rd_addr} < DEPTH_A;
    assign collide = wr_ok && rd_en && rd_ok && (wr_addr == rd_addr);

    // Parity to store for the incoming word; inj_err flips every bit so the
    // enabled bytes read back as corrupted. Without parity the field is 0.
    always_comb begin
        wr_par = '0;
        if (PARITY_ENABLE != 0) begin
            wr_par = NB'(byte_parity(MAX_DATA_WIDTH'(wr_data))) ^ {NB{inj_err}};
        end
    end

    // Byte-masked write port; disabled bytes keep data and parity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr[IW-1:0]][8*i +: 8]       <= wr_data[8*i +: 8];
                    mem[wr_addr[IW-1:0]][DATA_WIDTH + i] <= wr_par[i];
                end
            end
        end
    end

    // Stage 1: registered array read plus the write-side bypass terms. The
    // array read itself always returns the pre-write word; WRITE_FIRST
    // overlays the colliding bytes after the register.
    logic                  s1_valid;
    logic [WORD_W-1:0]     s1_raw;
    logic [NB-1:0]         s1_byp;
    logic [DATA_WIDTH-1:0] s1_wdata;
    logic [NB-1:0]         s1_wpar;

    // Stage-1 capture; out-of-range reads load an all-zero word, whose
    // parity is consistent so no error is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_raw   <= '0;
            s1_byp   <= '0;
            s1_wdata <= '0;
            s1_wpar  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_raw   <= rd_ok ? mem[rd_addr[IW-1:0]] : '0;
                s1_byp   <= (WRITE_FIRST && collide) ? wr_be : '0;
                s1_wdata <= wr_data;
                s1_wpar  <= wr_par;
            end
        end
    end

    logic [DATA_WIDTH-1:0] s1_data;
    logic [NB-1:0]         s1_par;

    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
        assign s1_data[8*gi +: 8] = s1_byp[gi] ? s1_wdata[8*gi +: 8] : s1_raw[8*gi +: 8];
        assign s1_par[gi]         = s1_byp[gi] ? s1_wpar[gi] : s1_raw[DATA_WIDTH + gi];
    end

    // Optional stage 2 for the two-cycle latency variant.
    logic                  last_valid;
    logic [DATA_WIDTH-1:0] last_data;
    logic [NB-1:0]         last_par;

    if (DOUT_PIPELINE != 0) begin : g_pipe
        logic                  s2_valid;
        logic [DATA_WIDTH-1:0] s2_data;
        logic [NB-1:0]         s2_par;

        // Stage 2 advances every cycle; there is no stall path.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
                s2_par   <= '0;
            end else begin
                s2_valid <= s1_valid;
                s2_data  <= s1_data;
                s2_par   <= s1_par;
            end
        end

        assign last_valid = s2_valid;
        assign last_data  = s2_data;
        assign last_par   = s2_par;
    end else begin : g_nopipe
        assign last_valid = s1_valid;
        assign last_data  = s1_data;
        assign last_par   = s1_par;
    end

    logic chk_err;

    ram_parity_chk #(
        .DATA_WIDTH (DATA_WIDTH),
        .NB         (NB)
    ) u_chk (
        .data (last_data),
        .par  (last_par),
        .err  (chk_err)
    );

    // Output register: data holds between reads, error is qualified by the
    // valid pulse, and the sticky flag latches one cycle after an error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            parity_err <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            rd_valid   <= last_valid;
            parity_err <= last_valid && chk_err && (PARITY_ENABLE != 0);
            err_sticky <= err_sticky | parity_err;
            if (last_valid) begin
                rd_data <= last_data;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_parity.sv
// Self-checking bench: two instances share the input stimulus.
//   dut_a: 1024 words, two-cycle latency, READ_FIRST
//   dut_b: 40 words (addresses >= 40 out of range), one-cycle, WRITE_FIRST
// A word-level model tracks contents and per-byte corruption flags.
module tb_dp_ram_parity;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        inj_err;
    logic        rd_en;
    logic [9:0]  rd_addr;

    logic [15:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic        a_parity_err, b_parity_err;
    logic        a_err_sticky, b_err_sticky;

    always #5 clk = ~clk;

    dp_ram_parity #(
        .DATA_WIDTH(16), .DEPTH(1024), .ADDR_SIZE(10), .DOUT_PIPELINE(1),
        .COLLISION_MODE("READ_FIRST"), .PARITY_ENABLE(1)
    ) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .inj_err(inj_err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .parity_err(a_parity_err),
        .err_sticky(a_err_sticky)
    );

    dp_ram_parity #(
        .DATA_WIDTH(16), .DEPTH(40), .ADDR_SIZE(10), .DOUT_PIPELINE(0),
        .COLLISION_MODE("WRITE_FIRST"), .PARITY_ENABLE(1)
    ) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .inj_err(inj_err), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .parity_err(b_parity_err),
        .err_sticky(b_err_sticky)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
        logic        perr;
    } exp_t;

    logic [15:0] m_data [64];
    logic [1:0]  m_bad  [64];   // per-byte "written with inj_err" flag
    exp_t        qa[$];
    exp_t        qb[$];
    int          cyc = 0;
    logic [15:0] last_a, last_b;
    logic        acc_a, acc_b;
    logic        exp_va, exp_vb, exp_pa, exp_pb, exp_sa, exp_sb;
    logic [15:0] exp_da, exp_db;

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a = '0; last_b = '0;
        acc_a  = 1'b0; acc_b = 1'b0;
    endtask

    task automatic set_idle();
        wr_en   = 1'b0;
        wr_addr = 10'($urandom_range(0, 63));
        wr_data = 16'($urandom);
        wr_be   = 2'b00;
        inj_err = 1'b0;
        rd_en   = 1'b0;
        rd_addr = 10'($urandom_range(0, 63));
    endtask

    // Advance one clock: update the model at the edge, then compute what
    // both instances should show at the following falling edge.
    task automatic tick();
        logic [15:0] old_w, new_w;
        logic [1:0]  old_b, new_b;
        exp_t        e;
        @(posedge clk);
        cyc++;
        if (rd_en) begin
            old_w = m_data[rd_addr[5:0]];
            old_b = m_bad[rd_addr[5:0]];
            new_w = old_w;
            new_b = old_b;
            if (wr_en && wr_addr == rd_addr) begin
                for (int i = 0; i < 2; i++) begin
                    if (wr_be[i]) begin
                        new_w[8*i +: 8] = wr_data[8*i +: 8];
                        new_b[i]        = inj_err;
                    end
                end
            end
            qa.push_back('{cyc + 2, old_w, |old_b});
            if (rd_addr >= 10'd40) qb.push_back('{cyc + 1, 16'h0000, 1'b0});
            else                   qb.push_back('{cyc + 1, new_w, |new_b});
        end
        if (wr_en) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_be[i]) begin
                    m_data[wr_addr[5:0]][8*i +: 8] = wr_data[8*i +: 8];
                    m_bad[wr_addr[5:0]][i]         = inj_err;
                end
            end
        end
        @(negedge clk);
        exp_va = 1'b0; exp_pa = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            e = qa.pop_front();
            exp_va = 1'b1; exp_pa = e.perr; last_a = e.data;
        end
        exp_da = last_a; exp_sa = acc_a; acc_a = acc_a | exp_pa;
        exp_vb = 1'b0; exp_pb = 1'b0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            e = qb.pop_front();
            exp_vb = 1'b1; exp_pb = e.perr; last_b = e.data;
        end
        exp_db = last_b; exp_sb = acc_b; acc_b = acc_b | exp_pb;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if ({a_rd_valid, a_rd_data, a_parity_err, a_err_sticky} !== 19'h0) begin
            tests_failed++;
            $display("FAIL reset_a got=%h exp=0", {a_rd_valid, a_rd_data, a_parity_err, a_err_sticky});
        end
        tests_run++;
        if ({b_rd_valid, b_rd_data, b_parity_err, b_err_sticky} !== 19'h0) begin
            tests_failed++;
            $display("FAIL reset_b got=%h exp=0", {b_rd_valid, b_rd_data, b_parity_err, b_err_sticky});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        $display("[TB] reset: outputs cleared");
    endtask

    task automatic preload();
        for (int a = 0; a < 64; a++) begin
            set_idle();
            wr_en = 1'b1; wr_addr = 10'(a); wr_data = 16'($urandom); wr_be = 2'b11;
            tick();
        end
        set_idle();
        $display("[TB] preload: 64 words written");
    endtask

    task automatic test_basic();
        set_idle(); wr_en = 1'b1; wr_addr = 10'd5; wr_data = 16'hA5C3; wr_be = 2'b11;
        tick();
        set_idle(); rd_en = 1'b1; rd_addr = 10'd5;
        tick();                                   // rd_en sampled here
        set_idle();
        tick();                                   // one-cycle instance delivers
        tests_run++;
        if ({b_rd_valid, b_rd_data, b_parity_err} !== {1'b1, 16'hA5C3, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_b got=%h exp=%h", {b_rd_valid, b_rd_data, b_parity_err}, {1'b1, 16'hA5C3, 1'b0});
        end
        tests_run++;
        if (a_rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_a_early got=%b exp=0", a_rd_valid);
        end
        tick();                                   // two-cycle instance delivers
        tests_run++;
        if ({a_rd_valid, a_rd_data, a_parity_err} !== {1'b1, 16'hA5C3, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_a got=%h exp=%h", {a_rd_valid, a_rd_data, a_parity_err}, {1'b1, 16'hA5C3, 1'b0});
        end
        tick();
        tests_run++;
        if ({a_rd_valid, a_rd_data} !== {1'b0, 16'hA5C3}) begin
            tests_failed++;
            $display("FAIL basic_a_hold got=%h exp=%h", {a_rd_valid, a_rd_data}, {1'b0, 16'hA5C3});
        end
        $display("[TB] basic: addr 5 = %h", a_rd_data);
    endtask

    task automatic test_byte_enable();
        set_idle(); wr_en = 1'b1; wr_addr = 10'd7; wr_data = 16'h1234; wr_be = 2'b11;
        tick();
        set_idle(); wr_en = 1'b1; wr_addr = 10'd7; wr_data = 16'hFF00; wr_be = 2'b10;
        tick();
        set_idle(); rd_en = 1'b1; rd_addr = 10'd7;
        tick();
        set_idle();
        tick();
        tests_run++;
        if ({b_rd_valid, b_rd_data} !== {1'b1, 16'hFF34}) begin
            tests_failed++;
            $display("FAIL byte_en_b got=%h exp=%h", {b_rd_valid, b_rd_data}, {1'b1, 16'hFF34});
        end
        tick();
        tests_run++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 16'hFF34}) begin
            tests_failed++;
            $display("FAIL byte_en_a got=%h exp=%h", {a_rd_valid, a_rd_data}, {1'b1, 16'hFF34});
        end
        $display("[TB] byte_enable: addr 7 = %h", a_rd_data);
    endtask

    task automatic test_collision();
        set_idle(); wr_en = 1'b1; wr_addr = 10'd3; wr_data = 16'h0001; wr_be = 2'b11;
        tick();
        set_idle(); wr_en = 1'b1; wr_addr = 10'd3; wr_data = 16'hBEEF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 10'd3;
        tick();
        set_idle();
        tick();
        tests_run++;
        if ({b_rd_valid, b_rd_data} !== {1'b1, 16'hBEEF}) begin
            tests_failed++;
            $display("FAIL coll_write_first got=%h exp=%h", {b_rd_valid, b_rd_data}, {1'b1, 16'hBEEF});
        end
        tick();
        tests_run++;
        if ({a_rd_valid, a_rd_data} !== {1'b1, 16'h0001}) begin
            tests_failed++;
            $display("FAIL coll_read_first got=%h exp=%h", {a_rd_valid, a_rd_data}, {1'b1, 16'h0001});
        end
        $display("[TB] collision: read_first=%h write_first=%h", a_rd_data, b_rd_data);
    endtask

    task automatic test_parity();
        set_idle(); wr_en = 1'b1; wr_addr = 10'd9; wr_data = 16'h5A3C; wr_be = 2'b01; inj_err = 1'b1;
        tick();
        set_idle(); rd_en = 1'b1; rd_addr = 10'd9;
        tick();
        set_idle();
        tick();
        tests_run++;
        if ({b_rd_valid, b_parity_err, b_err_sticky} !== 3'b110) begin
            tests_failed++;
            $display("FAIL parity_b got=%b exp=110", {b_rd_valid, b_parity_err, b_err_sticky});
        end
        tick();
        tests_run++;
        if ({a_rd_valid, a_parity_err, a_err_sticky, b_parity_err, b_err_sticky} !== 5'b11001) begin
            tests_failed++;
            $display("FAIL parity_a got=%b exp=11001", {a_rd_valid, a_parity_err, a_err_sticky, b_parity_err, b_err_sticky});
        end
        tick(); tick();
        tests_run++;
        if ({a_parity_err, a_err_sticky, b_err_sticky} !== 3'b011) begin
            tests_failed++;
            $display("FAIL sticky_hold got=%b exp=011", {a_parity_err, a_err_sticky, b_err_sticky});
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({a_err_sticky, b_err_sticky} !== 2'b00) begin
            tests_failed++;
            $display("FAIL sticky_clear got=%b exp=00", {a_err_sticky, b_err_sticky});
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] parity: error flagged, sticky held and cleared");
    endtask

    task automatic test_reset_inflight();
        for (int i = 0; i < 4; i++) begin
            set_idle(); rd_en = 1'b1; rd_addr = 10'(i);
            tick();
        end
        set_idle(); rd_en = 1'b1; rd_addr = 10'd4;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({a_rd_valid, a_rd_data, a_parity_err, b_rd_valid, b_rd_data, b_parity_err} !== 36'h0) begin
            tests_failed++;
            $display("FAIL async_reset got=%h exp=0", {a_rd_valid, a_rd_data, a_parity_err, b_rd_valid, b_rd_data, b_parity_err});
        end
        rd_en = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_idle();
            tick();
            tests_run++;
            if ({a_rd_valid, b_rd_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL no_valid_after_reset got=%b exp=00", {a_rd_valid, b_rd_valid});
            end
        end
        for (int i = 0; i < 7; i++) begin
            set_idle();
            if (i < 4) begin rd_en = 1'b1; rd_addr = 10'(4 + i); end
            tick();
            tests_run++;
            if ({a_rd_valid, a_rd_data, a_parity_err} !== {exp_va, exp_da, exp_pa}) begin
                tests_failed++;
                $display("FAIL post_reset_a got=%h exp=%h", {a_rd_valid, a_rd_data, a_parity_err}, {exp_va, exp_da, exp_pa});
            end
            tests_run++;
            if ({b_rd_valid, b_rd_data, b_parity_err} !== {exp_vb, exp_db, exp_pb}) begin
                tests_failed++;
                $display("FAIL post_reset_b got=%h exp=%h", {b_rd_valid, b_rd_data, b_parity_err}, {exp_vb, exp_db, exp_pb});
            end
        end
        $display("[TB] reset_inflight: in-flight reads discarded");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 19; i++) begin
            set_idle();
            if (i < 16) begin
                wr_en = 1'b1; wr_addr = 10'(i); wr_data = 16'($urandom); wr_be = 2'b11;
                rd_en = 1'b1; rd_addr = 10'(16 + i);
            end
            tick();
            tests_run++;
            if ({b_rd_valid, b_rd_data, b_parity_err} !== {exp_vb, exp_db, exp_pb}) begin
                tests_failed++;
                $display("FAIL stream_b cyc=%0d got=%h exp=%h", cyc, {b_rd_valid, b_rd_data, b_parity_err}, {exp_vb, exp_db, exp_pb});
            end
            tests_run++;
            if ({a_rd_valid, a_rd_data, a_parity_err} !== {exp_va, exp_da, exp_pa}) begin
                tests_failed++;
                $display("FAIL stream_a cyc=%0d got=%h exp=%h", cyc, {a_rd_valid, a_rd_data, a_parity_err}, {exp_va, exp_da, exp_pa});
            end
        end
        $display("[TB] stream: 16 concurrent writes and reads");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_idle();
            if (i < 296) begin
                wr_en   = 1'($urandom_range(0, 1));
                wr_addr = 10'($urandom_range(0, 63));
                wr_data = 16'($urandom);
                wr_be   = 2'($urandom_range(0, 3));
                inj_err = ($urandom_range(0, 15) == 0);
                rd_en   = ($urandom_range(0, 3) != 0);
                rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 10'($urandom_range(0, 63));
            end
            tick();
            tests_run++;
            if ({a_rd_valid, a_rd_data, a_parity_err, a_err_sticky} !== {exp_va, exp_da, exp_pa, exp_sa}) begin
                tests_failed++;
                $display("FAIL random_a cyc=%0d got=%h exp=%h", cyc, {a_rd_valid, a_rd_data, a_parity_err, a_err_sticky}, {exp_va, exp_da, exp_pa, exp_sa});
            end
            tests_run++;
            if ({b_rd_valid, b_rd_data, b_parity_err, b_err_sticky} !== {exp_vb, exp_db, exp_pb, exp_sb}) begin
                tests_failed++;
                $display("FAIL random_b cyc=%0d got=%h exp=%h", cyc, {b_rd_valid, b_rd_data, b_parity_err, b_err_sticky}, {exp_vb, exp_db, exp_pb, exp_sb});
            end
        end
        $display("[TB] random: 300 cycles compared against model");
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_byte_enable();
        test_collision();
        test_parity();
        test_reset_inflight();
        test_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1, "timeout");
    end

endmodule
